// File: rtl/jacobi2d_unrolled_1_pkg.sv
// Shared constants and types for the jacobi2d delay-line tap reader.
package jacobi2d_unrolled_1_pkg;

  localparam int unsigned DEPTH = 2054;
  localparam int unsigned PRIME = DEPTH - 1;
  localparam int unsigned NTAPS = 5;
  localparam int unsigned TAP_AW = 12;

  // Read offsets relative to the bank write pointer; tap0 in the LSB slot.
  // 2053 hits the newest word, 1 the oldest word still held.
  localparam logic [NTAPS-1:0][TAP_AW-1:0] TAP_OFF = {
    12'd1, 12'd1026, 12'd1027, 12'd1028, 12'd2053
  };

  typedef enum logic [1:0] {
    StAccept,
    StRead,
    StFlush,
    StOut
  } state_e;

endpackage

// File: rtl/jacobi2d_unrolled_1_tap_capture.sv
// Five-slot tap capture register with indexed write and flattened output.
module jacobi2d_unrolled_1_tap_capture #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NTAPS = 5,
  parameter int unsigned IW    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [IW-1:0]          idx_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [NTAPS*WIDTH-1:0] data_o
);

  logic [NTAPS-1:0][WIDTH-1:0] slots_q;

  // Write the selected slot; reset clears any partially captured tuple.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
    end else if (en_i) begin
      slots_q[idx_i] <= data_i;
    end
  end

  assign data_o = slots_q;

endmodule

// File: rtl/jacobi2d_unrolled_1_tap_reader.sv
// Stream-side controller: writes input pixels into the delay-line bank, then
// reads the five stencil taps back and presents them as one tuple.
module jacobi2d_unrolled_1_tap_reader
  import jacobi2d_unrolled_1_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2054,
  parameter int unsigned AW    = 12,
  parameter int unsigned NTAPS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   bank_wen,
  output logic [WIDTH-1:0]       bank_wdata,
  output logic [AW-1:0]          bank_raddr,
  input  logic [WIDTH-1:0]       bank_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NTAPS*WIDTH-1:0] out_data,
  output logic                   primed
);

  localparam int unsigned IW = 3;
  localparam logic [AW-1:0] Prime = AW'(DEPTH - 1);
  localparam logic [IW-1:0] LastIdx = IW'(NTAPS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] fill_q, fill_d, fill_inc;
  logic [IW-1:0] idx_q, idx_d;
  logic          cap_en;
  logic [IW-1:0] cap_idx;

  // Saturating fill count; once primed every accepted pixel yields a tuple.
  assign fill_inc = (fill_q >= Prime) ? Prime : fill_q + 1'b1;
  assign primed   = (fill_q == Prime);

  // State, fill count and tap index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccept;
      fill_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state decode and handshake/bank outputs.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    idx_d      = idx_q;
    in_ready   = 1'b0;
    bank_wen   = 1'b0;
    bank_wdata = in_data;
    bank_raddr = '0;
    out_valid  = 1'b0;
    cap_en     = 1'b0;
    cap_idx    = '0;

    unique case (state_q)
      StAccept: begin
        in_ready = 1'b1;
        // No writes while reset is held so the bank pointer stays aligned.
        if (in_valid && !rst) begin
          bank_wen = 1'b1;
          fill_d   = fill_inc;
          if (fill_inc >= Prime) begin
            state_d = StRead;
            idx_d   = '0;
          end
        end
      end
      StRead: begin
        bank_raddr = AW'(TAP_OFF[idx_q]);
        // Read data lags the address by one cycle.
        if (idx_q != '0) begin
          cap_en  = 1'b1;
          cap_idx = idx_q - 1'b1;
        end
        if (idx_q == LastIdx) begin
          state_d = StFlush;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFlush: begin
        cap_en  = 1'b1;
        cap_idx = LastIdx;
        state_d = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StAccept;
        end
      end
      default: begin
        state_d = StAccept;
      end
    endcase
  end

  jacobi2d_unrolled_1_tap_capture #(
    .WIDTH(WIDTH),
    .NTAPS(NTAPS),
    .IW   (IW)
  ) u_capture (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (cap_en),
    .idx_i (cap_idx),
    .data_i(bank_rdata),
    .data_o(out_data)
  );

endmodule
